// File: rtl/if_prefetch_stage_if.sv
// if_prefetch_stage_if
// Bundles the fetch stage's external signals: the instruction-memory read
// port, the decode-side valid/ready handshake, and the branch/jump redirect.
//
// Signals
//   redirect_valid / redirect_addr : taken branch/jump and its target
//   imem_req / imem_addr           : read request and its address
//   imem_rdata                     : read data for the previous cycle's request
//   out_valid / out_ready          : decode handshake for the queue head
//   out_instr / out_pc / out_pc_next : head instruction, its address, address + step
//
// Modports
//   master : the fetch stage
//   slave  : the environment (memory, decode, branch unit)
interface if_prefetch_stage_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [ADDR_WIDTH-1:0] out_pc_next;

  modport master (
    input  redirect_valid, redirect_addr, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_next
  );

  modport slave (
    output redirect_valid, redirect_addr, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_next
  );
endinterface

// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage
// Instruction-fetch stage: PC generator, synchronous-read instruction-memory
// port and a DEPTH-entry prefetch queue feeding decode through valid/ready.
// A redirect flushes every fetched-but-unconsumed instruction and restarts
// fetching at the target.
//
// Ports
//   clock   : single clock, all state updates on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : if_prefetch_stage_if.master (imem port, decode handshake, redirect)
module if_prefetch_stage #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DEPTH      = 4,
  parameter int                    PC_STEP    = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  if_prefetch_stage_if.master  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  discard;

  logic [DATA_WIDTH-1:0] q_instr [DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc    [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;

  logic [CW:0]           pending;
  logic                  issue_en;
  logic                  push_en;
  logic                  pop_en;

  // Credit: queued entries plus the one possibly in flight must leave room,
  // so a returning read can never find the queue full.
  assign pending  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue_en = (pending < (CW + 1)'(DEPTH)) && !bus.redirect_valid && reset_n;

  // Redirect outranks both queue operations; the handshake in a redirect
  // cycle is squashed along with the queue contents.
  assign push_en  = inflight && !discard && !bus.redirect_valid;
  assign pop_en   = (count != '0) && bus.out_ready && !bus.redirect_valid;

  // Pointer wrap at DEPTH, not at a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      discard     <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_addr;
      end else if (issue_en) begin
        fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_STEP);
      end

      inflight <= issue_en;
      if (issue_en) begin
        inflight_pc <= fetch_pc;
      end

      // Marks a return that still belongs to the flushed stream.
      discard <= bus.redirect_valid && inflight;

      if (bus.redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_en) begin
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (pop_en) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        if (push_en && !pop_en) begin
          count <= count + 1'b1;
        end else if (pop_en && !push_en) begin
          count <= count - 1'b1;
        end
      end
    end
  end

  // Queue storage carries no reset; its contents only matter while count
  // says they are live.
  always_ff @(posedge clock) begin
    if (push_en) begin
      q_instr[wr_ptr] <= bus.imem_rdata;
      q_pc[wr_ptr]    <= inflight_pc;
    end
  end

  assign bus.imem_req    = issue_en;
  assign bus.imem_addr   = fetch_pc;
  assign bus.out_valid   = (count != '0);
  assign bus.out_instr   = q_instr[rd_ptr];
  assign bus.out_pc      = q_pc[rd_ptr];
  assign bus.out_pc_next = q_pc[rd_ptr] + ADDR_WIDTH'(PC_STEP);

endmodule

// File: tb/tb_if_prefetch_stage.sv
module tb_if_prefetch_stage;
  localparam int          DW    = 16;
  localparam int          AW    = 16;
  localparam int          DEPTH = 4;
  localparam int          STEP  = 2;
  localparam logic [15:0] RPC   = 16'hFFFC;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  if_prefetch_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  if_prefetch_stage #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .PC_STEP(STEP), .RESET_PC(RPC)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents are a fixed function of the address.
  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Synchronous-read memory: data for a request appears in the next cycle.
  always @(posedge clock) begin
    if (reset_n && bus.imem_req)
      bus.imem_rdata <= mem_f(bus.imem_addr);
    else
      bus.imem_rdata <= 16'($urandom);
  end

  // Reference model: mq holds pcs visible to decode in order, mpipe holds
  // pcs requested but not yet returned, mfpc is the next address to fetch.
  logic [15:0] mq[$];
  logic [15:0] mpipe[$];
  logic [15:0] mfpc = RPC;
  logic        exp_valid;
  logic        exp_req;

  always @(negedge clock) begin
    if (!reset_n) begin
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_imem_req",  32'(bus.imem_req),  32'h0);
      mq.delete();
      mpipe.delete();
      mfpc = RPC;
    end else begin
      exp_valid = (mq.size() != 0);
      exp_req   = ((mq.size() + mpipe.size()) < DEPTH) && !bus.redirect_valid;
      check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      check("imem_req",  32'(bus.imem_req),  32'(exp_req));
      if (exp_req)
        check("imem_addr", 32'(bus.imem_addr), 32'(mfpc));
      if (exp_valid) begin
        check("out_pc",      32'(bus.out_pc),      32'(mq[0]));
        check("out_instr",   32'(bus.out_instr),   32'(mem_f(mq[0])));
        check("out_pc_next", 32'(bus.out_pc_next), 32'(16'(mq[0] + 16'(STEP))));
      end
      check("no_overflow", 32'(dut.push_en && (int'(dut.count) == DEPTH)), 32'h0);

      if (bus.redirect_valid) begin
        mq.delete();
        mpipe.delete();
        mfpc = bus.redirect_addr;
      end else begin
        if (exp_valid && bus.out_ready)
          void'(mq.pop_front());
        if (mpipe.size() != 0)
          mq.push_back(mpipe.pop_front());
        if (exp_req) begin
          mpipe.push_back(mfpc);
          mfpc = mfpc + 16'(STEP);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n            = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    bus.out_ready      = 1'b1;
    repeat (3) cyc();

    // Cycle 0 after release, then the wrap across 0xFFFF.
    reset_n = 1'b1;
    @(negedge clock);
    check("c0_req",  32'(bus.imem_req),  32'h1);
    check("c0_addr", 32'(bus.imem_addr), 32'hFFFC);
    cyc(); @(negedge clock);
    check("c1_valid", 32'(bus.out_valid), 32'h0);
    cyc(); @(negedge clock);
    check("c2_valid", 32'(bus.out_valid), 32'h1);
    check("c2_pc",    32'(bus.out_pc),    32'hFFFC);
    cyc(); @(negedge clock);
    check("c3_pc",      32'(bus.out_pc),      32'hFFFE);
    check("c3_pc_next", 32'(bus.out_pc_next), 32'h0000);
    cyc(); @(negedge clock);
    check("c4_pc", 32'(bus.out_pc), 32'h0000);
    repeat (6) cyc();

    // Back-pressure until credit runs out, then drain.
    bus.out_ready = 1'b0;
    repeat (8) cyc();
    @(negedge clock);
    check("stall_req",   32'(bus.imem_req),  32'h0);
    check("stall_valid", 32'(bus.out_valid), 32'h1);
    cyc();
    bus.out_ready = 1'b1;
    repeat (8) cyc();

    // Single redirect while streaming.
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 16'h0100;
    cyc();
    bus.redirect_valid = 1'b0;
    @(negedge clock);
    check("r1_req",   32'(bus.imem_req),  32'h1);
    check("r1_addr",  32'(bus.imem_addr), 32'h0100);
    check("r1_valid", 32'(bus.out_valid), 32'h0);
    cyc(); @(negedge clock);
    check("r2_valid", 32'(bus.out_valid), 32'h0);
    cyc(); @(negedge clock);
    check("r3_valid", 32'(bus.out_valid), 32'h1);
    check("r3_pc",    32'(bus.out_pc),    32'h0100);
    cyc(); @(negedge clock);
    check("r4_pc", 32'(bus.out_pc), 32'h0102);
    repeat (3) cyc();

    // Two consecutive redirects with a same-cycle pop: the last one wins.
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 16'h0200;
    cyc();
    bus.redirect_addr  = 16'h0300;
    cyc();
    bus.redirect_valid = 1'b0;
    cyc();
    cyc(); @(negedge clock);
    check("dr_pc", 32'(bus.out_pc), 32'h0300);
    cyc(); @(negedge clock);
    check("dr_pc2", 32'(bus.out_pc), 32'h0302);
    cyc();

    // Randomized traffic checked against the model.
    repeat (400) begin
      bus.out_ready      = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_addr  = 16'($urandom) & 16'hFFFE;
      cyc();
    end
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    repeat (4) cyc();

    // Asynchronous reset with a full queue, then restart.
    bus.out_ready = 1'b0;
    repeat (8) cyc();
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'h0);
    check("arst_req",   32'(bus.imem_req),  32'h0);
    repeat (2) cyc();
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    check("rs_req",  32'(bus.imem_req),  32'h1);
    check("rs_addr", 32'(bus.imem_addr), 32'hFFFC);
    cyc();
    cyc(); @(negedge clock);
    check("rs_valid", 32'(bus.out_valid), 32'h1);
    check("rs_pc",    32'(bus.out_pc),    32'hFFFC);
    repeat (10) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
